eth_rx_frame_stats: RTL and testbench
=====================================

// Module: eth_rx_frame_stats
// PURPOSE
// - Passive statistics monitor on the RX AXI-Stream output of the 1G MAC (rx_axis_*), downstream of the GMII receiver.
// - Measures frame lengths and accumulates good/bad frame and byte counts.
// - Exposes the counts as an atomically captured snapshot for register readout.
// - Never backpressures: the source has no tready, so every valid beat is consumed.
// PARAMETERS
// - DATA_WIDTH        8     stream width; only 8 supported, other values are a elaboration error
// - COUNTER_WIDTH     64    width of every accumulated counter
// - MIN_FRAME_LENGTH  64    frames shorter than this (bytes, incl. FCS) are runts
// - MAX_FRAME_LENGTH  1518  frames longer than this are oversize (ETH_RX_STATS_OVERSIZE_EN only)
// PORTS
// - clk              in   1              single clock, RX MAC domain
// - rst_n            in   1              asynchronous, active-low reset
// - s_axis_tdata     in   DATA_WIDTH     frame byte, ignored except for counting
// - s_axis_tvalid    in   1              beat valid
// - s_axis_tlast     in   1              last beat of frame
// - s_axis_tuser     in   3              bit0 = frame error (bad FCS/rx_er); bits 2:1 ignored
// - snapshot_req     in   1              pulse: capture counters into outputs
// - clear_req        in   1              pulse: zero internal counters
// - snapshot_valid   out  1              one-cycle pulse, snapshot outputs updated
// - good_frames      out  COUNTER_WIDTH  snapshot: frames with tuser[0]=0 at tlast
// - bad_frames       out  COUNTER_WIDTH  snapshot: frames with tuser[0]=1 at tlast
// - good_bytes       out  COUNTER_WIDTH  snapshot: sum of good frame lengths
// - bad_bytes        out  COUNTER_WIDTH  snapshot: sum of bad frame lengths
// - runt_frames      out  COUNTER_WIDTH  snapshot: frames with length < MIN_FRAME_LENGTH (good or bad)
// - oversize_frames  out  COUNTER_WIDTH  snapshot: frames > MAX_FRAME_LENGTH; tied 0 without macro
// - last_frame_len   out  16             length of most recent completed frame, live (not snapshot)
// - frame_active     out  1              high while in FRAME state
// BEHAVIOUR
// - Reset (rst_n=0): all outputs and internal counters 0; FSM -> SYNC.
// - FSM: SYNC  : discard beats; on valid&tlast -> IDLE (partial frame never counted).
//        IDLE  : valid&!tlast -> FRAME, len=1; valid&tlast -> 1-byte frame completes, stay IDLE.
//        FRAME : each valid beat len+=1; on valid&tlast frame completes (length = len+1) -> IDLE.
// - Per-frame length counter 16 bit, saturates at 0xFFFF; the saturated value is used for bytes and classification.
// - Completion registered into pending stage; internal counters update 1 cycle after the tlast beat.
// - last_frame_len updates on the same cycle the internal counters update.
// - Classification: tuser[0] sampled only on the tlast beat; error on earlier beats is ignored.
// - Counters wrap modulo 2^COUNTER_WIDTH; no saturation.
// - snapshot_req: outputs <= internal counters as of that cycle (pending update excluded);
//   snapshot_valid pulses the following cycle; snapshot outputs hold until next snapshot.
// - clear_req: internal counters <= 0 plus any pending update applied that cycle (contribution is not lost).
//   Snapshot outputs are not cleared.
// - snapshot_req and clear_req in same cycle: snapshot captures pre-clear values, then clear.
// - Back-to-back frames (tlast followed immediately by next valid) are fully supported; no idle cycle required.
// - tvalid gaps inside a frame do not alter the count.
// CONFIGURATION
// - ETH_RX_STATS_OVERSIZE_EN defined:
//   oversize counter implemented; increments when length > MAX_FRAME_LENGTH (good or bad), snapshot/clear as others.
// - Not defined: no counter logic; oversize_frames driven constant 0.
// TESTING
// - Reset, then 64-byte good frame, snapshot -> good_frames=1, good_bytes=64, runt_frames=0, last_frame_len=64.
// - 40-byte frame with tuser[0]=1 on tlast -> bad_frames=1, bad_bytes=40, runt_frames=1, good counters unchanged.
// - Release rst_n mid-frame (30 beats remain) then one 100-byte frame -> good_frames=1, good_bytes=100.
// - tlast of 70-byte frame, next cycle clear_req with snapshot_req -> snapshot shows prior totals;
//   next snapshot shows good_frames=1, good_bytes=70.
// - 1519-byte good frame: macro on -> oversize_frames=1; macro off -> oversize_frames=0;
//   good_bytes=1519 in both builds.
// - Two back-to-back 64-byte frames, no gap, tvalid toggling within frames -> good_frames=2, good_bytes=128.

Source files
------------

// File: rtl/eth_rx_frame_stats_if.sv
// RX AXI-Stream beat bundle between the 1G MAC receive path and its observers.
// The source has no tready: every beat presented with tvalid high is consumed.
interface eth_rx_frame_stats_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic [2:0]            tuser;

    modport master (output tdata, tvalid, tlast, tuser);
    modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/eth_rx_frame_stats.sv
// Passive frame statistics monitor for the 1G MAC RX stream.
// Counts good/bad frames and bytes plus runts, and publishes them as an
// atomically captured snapshot. Optional feature macro:
//   ETH_RX_STATS_OVERSIZE_EN - adds the oversize frame counter
//                              (otherwise oversize_frames is tied to 0).
module eth_rx_frame_stats #(
    parameter int DATA_WIDTH       = 8,
    parameter int COUNTER_WIDTH    = 64,
    parameter int MIN_FRAME_LENGTH = 64,
    parameter int MAX_FRAME_LENGTH = 1518
) (
    input  logic                     clk,
    input  logic                     rst_n,
    eth_rx_frame_stats_if.slave      s_axis,
    input  logic                     snapshot_req,
    input  logic                     clear_req,
    output logic                     snapshot_valid,
    output logic [COUNTER_WIDTH-1:0] good_frames,
    output logic [COUNTER_WIDTH-1:0] bad_frames,
    output logic [COUNTER_WIDTH-1:0] good_bytes,
    output logic [COUNTER_WIDTH-1:0] bad_bytes,
    output logic [COUNTER_WIDTH-1:0] runt_frames,
    output logic [COUNTER_WIDTH-1:0] oversize_frames,
    output logic [15:0]              last_frame_len,
    output logic                     frame_active
);

    if (DATA_WIDTH != 8) begin : g_bad_width
        $error("eth_rx_frame_stats: only DATA_WIDTH = 8 is supported");
    end

    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LENGTH);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FRAME = 2'd2
    } state_e;

    typedef struct packed {
        logic [COUNTER_WIDTH-1:0] good_frames;
        logic [COUNTER_WIDTH-1:0] bad_frames;
        logic [COUNTER_WIDTH-1:0] good_bytes;
        logic [COUNTER_WIDTH-1:0] bad_bytes;
        logic [COUNTER_WIDTH-1:0] runt_frames;
    } stats_t;

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic        pend_valid_q, pend_valid_d;
    logic [15:0] pend_len_q, pend_len_d;
    logic        pend_err_q, pend_err_d;
    stats_t      cnt_q, cnt_d, cnt_base;
    stats_t      snap_q, snap_d;
    logic        snapshot_valid_q, snapshot_valid_d;
    logic [15:0] last_len_q, last_len_d;

    logic                     is_good, is_bad, is_runt;
    logic [COUNTER_WIDTH-1:0] pend_bytes;

    // Payload bits and error-detail bits are only observed, never counted.
    logic unused_bits;
    assign unused_bits = ^{s_axis.tdata, s_axis.tuser[2:1]};

    // Frame delineation: sync to the first frame end, then count beats per frame
    // and hand each completed frame to the pending stage.
    // NOTE: every output of this block gets a default first, so no path can leave
    // a variable unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        pend_valid_d = 1'b0;
        pend_len_d   = pend_len_q;
        pend_err_d   = pend_err_q;
        if (s_axis.tvalid) begin
            unique case (state_q)
                ST_SYNC: begin
                    // Tail of a frame already in flight at reset: drop it.
                    if (s_axis.tlast) state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (s_axis.tlast) begin
                        pend_valid_d = 1'b1;
                        pend_len_d   = 16'd1;
                        pend_err_d   = s_axis.tuser[0];
                    end else begin
                        state_d = ST_FRAME;
                        len_d   = 16'd1;
                    end
                end
                ST_FRAME: begin
                    len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
                    if (s_axis.tlast) begin
                        pend_valid_d = 1'b1;
                        pend_len_d   = len_d;
                        pend_err_d   = s_axis.tuser[0];
                        state_d      = ST_IDLE;
                    end
                end
                default: state_d = ST_SYNC;
            endcase
        end
    end

    assign is_good    = pend_valid_q & ~pend_err_q;
    assign is_bad     = pend_valid_q &  pend_err_q;
    assign is_runt    = pend_valid_q & (pend_len_q < MIN_LEN);
    assign pend_bytes = COUNTER_WIDTH'(pend_len_q);

    // Counter accumulation, clear and snapshot capture. A clear restarts from zero
    // but still folds in the pending frame; a snapshot sees pre-clear, pre-pending values.
    always_comb begin
        cnt_base          = clear_req ? '0 : cnt_q;
        cnt_d             = cnt_base;
        cnt_d.good_frames = cnt_base.good_frames + COUNTER_WIDTH'(is_good);
        cnt_d.bad_frames  = cnt_base.bad_frames  + COUNTER_WIDTH'(is_bad);
        cnt_d.good_bytes  = cnt_base.good_bytes  + (is_good ? pend_bytes : '0);
        cnt_d.bad_bytes   = cnt_base.bad_bytes   + (is_bad  ? pend_bytes : '0);
        cnt_d.runt_frames = cnt_base.runt_frames + COUNTER_WIDTH'(is_runt);
        snap_d            = snapshot_req ? cnt_q : snap_q;
        snapshot_valid_d  = snapshot_req;
        last_len_d        = pend_valid_q ? pend_len_q : last_len_q;
    end

    // State, pending stage, counters and snapshot registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_SYNC;
            len_q            <= '0;
            pend_valid_q     <= 1'b0;
            pend_len_q       <= '0;
            pend_err_q       <= 1'b0;
            cnt_q            <= '0;
            snap_q           <= '0;
            snapshot_valid_q <= 1'b0;
            last_len_q       <= '0;
        end else begin
            state_q          <= state_d;
            len_q            <= len_d;
            pend_valid_q     <= pend_valid_d;
            pend_len_q       <= pend_len_d;
            pend_err_q       <= pend_err_d;
            cnt_q            <= cnt_d;
            snap_q           <= snap_d;
            snapshot_valid_q <= snapshot_valid_d;
            last_len_q       <= last_len_d;
        end
    end

`ifdef ETH_RX_STATS_OVERSIZE_EN
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LENGTH);

    logic [COUNTER_WIDTH-1:0] over_cnt_q, over_cnt_d;
    logic [COUNTER_WIDTH-1:0] over_snap_q, over_snap_d;
    logic                     is_over;

    assign is_over = pend_valid_q & (pend_len_q > MAX_LEN);

    // Oversize counter follows the same clear/snapshot rules as the others.
    always_comb begin
        over_cnt_d  = (clear_req ? '0 : over_cnt_q) + COUNTER_WIDTH'(is_over);
        over_snap_d = snapshot_req ? over_cnt_q : over_snap_q;
    end

    // Oversize counter and its snapshot register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            over_cnt_q  <= '0;
            over_snap_q <= '0;
        end else begin
            over_cnt_q  <= over_cnt_d;
            over_snap_q <= over_snap_d;
        end
    end

    assign oversize_frames = over_snap_q;
`else
    logic unused_max;
    assign unused_max      = (MAX_FRAME_LENGTH > 0);
    assign oversize_frames = '0;
`endif

    assign snapshot_valid = snapshot_valid_q;
    assign good_frames    = snap_q.good_frames;
    assign bad_frames     = snap_q.bad_frames;
    assign good_bytes     = snap_q.good_bytes;
    assign bad_bytes      = snap_q.bad_bytes;
    assign runt_frames    = snap_q.runt_frames;
    assign last_frame_len = last_len_q;
    assign frame_active   = (state_q == ST_FRAME);

endmodule

// File: tb/tb_eth_rx_frame_stats.sv
// Self-checking bench for eth_rx_frame_stats: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// frame-level model. Honours ETH_RX_STATS_OVERSIZE_EN like the design.
module tb_eth_rx_frame_stats;

    localparam int CW = 64;

`ifdef ETH_RX_STATS_OVERSIZE_EN
    localparam bit OVER_EN = 1'b1;
`else
    localparam bit OVER_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic snapshot_req = 1'b0;
    logic clear_req = 1'b0;
    logic          snapshot_valid;
    logic [CW-1:0] good_frames, bad_frames, good_bytes, bad_bytes, runt_frames, oversize_frames;
    logic [15:0]   last_frame_len;
    logic          frame_active;

    always #5 clk = ~clk;

    eth_rx_frame_stats_if #(.DATA_WIDTH(8)) s_axis ();

    eth_rx_frame_stats #(
        .DATA_WIDTH(8), .COUNTER_WIDTH(CW), .MIN_FRAME_LENGTH(64), .MAX_FRAME_LENGTH(1518)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_axis(s_axis),
        .snapshot_req(snapshot_req), .clear_req(clear_req),
        .snapshot_valid(snapshot_valid),
        .good_frames(good_frames), .bad_frames(bad_frames),
        .good_bytes(good_bytes), .bad_bytes(bad_bytes),
        .runt_frames(runt_frames), .oversize_frames(oversize_frames),
        .last_frame_len(last_frame_len), .frame_active(frame_active)
    );

    int tests = 0;
    int fails = 0;
    bit done = 1'b0;
    bit rand_reqs = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    typedef struct {
        int len;
        bit err;
    } frame_t;
    frame_t fq[$];

    logic [63:0] m_good_f = 0, m_bad_f = 0, m_good_b = 0, m_bad_b = 0, m_runt = 0, m_over = 0;
    logic [63:0] e_good_f = 0, e_bad_f = 0, e_good_b = 0, e_bad_b = 0, e_runt = 0, e_over = 0;
    bit          m_synced = 0;
    bit          m_pend = 0;
    int          m_pend_len = 0;
    bit          m_pend_err = 0;
    bit          e_active = 0;
    bit          e_snap_valid = 0;
    int          e_last_len = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_good_f = 0; m_bad_f = 0; m_good_b = 0; m_bad_b = 0; m_runt = 0; m_over = 0;
                e_good_f = 0; e_bad_f = 0; e_good_b = 0; e_bad_b = 0; e_runt = 0; e_over = 0;
                m_synced = 0; m_pend = 0; e_active = 0; e_snap_valid = 0; e_last_len = 0;
            end else begin
                e_snap_valid = snapshot_req;
                if (snapshot_req) begin
                    e_good_f = m_good_f; e_bad_f = m_bad_f; e_good_b = m_good_b;
                    e_bad_b = m_bad_b; e_runt = m_runt; e_over = m_over;
                end
                if (clear_req) begin
                    m_good_f = 0; m_bad_f = 0; m_good_b = 0; m_bad_b = 0; m_runt = 0; m_over = 0;
                end
                if (m_pend) begin
                    if (m_pend_err) begin
                        m_bad_f += 1;
                        m_bad_b += 64'(m_pend_len);
                    end else begin
                        m_good_f += 1;
                        m_good_b += 64'(m_pend_len);
                    end
                    if (m_pend_len < 64) m_runt += 1;
                    if (OVER_EN && m_pend_len > 1518) m_over += 1;
                    e_last_len = m_pend_len;
                end
                m_pend = 0;
                if (s_axis.tvalid && s_axis.tlast) begin
                    if (fq.size() == 0) begin
                        check("model_frame_queue_empty", 64'd1, 64'd0);
                    end else begin
                        frame_t f;
                        f = fq.pop_front();
                        if (m_synced) begin
                            m_pend     = 1;
                            m_pend_len = (f.len > 65535) ? 65535 : f.len;
                            m_pend_err = f.err;
                        end
                    end
                    m_synced = 1;
                    e_active = 0;
                end else if (s_axis.tvalid && m_synced) begin
                    e_active = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!done) begin
                check("frame_active", frame_active, e_active);
                check("last_frame_len", last_frame_len, e_last_len);
                check("snapshot_valid", snapshot_valid, e_snap_valid);
                check("good_frames", good_frames, e_good_f);
                check("bad_frames", bad_frames, e_bad_f);
                check("good_bytes", good_bytes, e_good_b);
                check("bad_bytes", bad_bytes, e_bad_b);
                check("runt_frames", runt_frames, e_runt);
                check("oversize_frames", oversize_frames, e_over);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        if (rand_reqs) begin
            snapshot_req = ($urandom_range(0, 19) == 0);
            clear_req    = ($urandom_range(0, 39) == 0);
        end else begin
            snapshot_req = 1'b0;
            clear_req    = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            s_axis.tvalid = 1'b0;
            s_axis.tlast  = 1'b0;
            s_axis.tdata  = 8'($urandom);
            s_axis.tuser  = 3'($urandom);
            step();
        end
    endtask

    task automatic send_frame(input int len, input bit err, input bit gaps, input int rel_at = -1);
        fq.push_back('{len, err});
        for (int i = 0; i < len; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            if (i == rel_at) rst_n = 1'b1;
            s_axis.tvalid = 1'b1;
            s_axis.tlast  = (i == len - 1);
            s_axis.tdata  = 8'($urandom);
            s_axis.tuser  = {2'($urandom), (i == len - 1) ? err : 1'($urandom)};
            step();
        end
    endtask

    task automatic req(input bit snap, input bit clr);
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        snapshot_req  = snap;
        clear_req     = clr;
        @(negedge clk);
        snapshot_req  = 1'b0;
        clear_req     = 1'b0;
    endtask

    task automatic wait_snap_valid();
        int n = 0;
        while (!snapshot_valid && n < 4) begin
            @(negedge clk);
            n++;
        end
        check("snapshot_valid_seen", snapshot_valid, 1);
    endtask

    task automatic snap_check();
        req(1'b1, 1'b0);
        wait_snap_valid();
    endtask

    // Literal expectation pinned on both the DUT and the model.
    task automatic lit(input string name, input logic [63:0] dut_v, input logic [63:0] mdl_v,
                       input logic [63:0] exp);
        check({"lit_", name}, dut_v, exp);
        check({"lit_model_", name}, mdl_v, exp);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tuser  = '0;
        repeat (3) @(negedge clk);
        check("reset_frame_active", frame_active, 0);
        check("reset_good_frames", good_frames, 0);
        check("reset_last_frame_len", last_frame_len, 0);
        rst_n = 1'b1;
        idle(2);

        // Sync beat after reset, then a 64-byte good frame.
        send_frame(1, 1'b0, 1'b0);
        send_frame(64, 1'b0, 1'b0);
        idle(2);
        snap_check();
        lit("t1_good_frames", good_frames, e_good_f, 1);
        lit("t1_good_bytes", good_bytes, e_good_b, 64);
        lit("t1_runt_frames", runt_frames, e_runt, 0);
        lit("t1_last_len", last_frame_len, 64'(e_last_len), 64);

        // 40-byte bad runt; error noise on earlier beats must be ignored.
        send_frame(40, 1'b1, 1'b1);
        idle(2);
        snap_check();
        lit("t2_bad_frames", bad_frames, e_bad_f, 1);
        lit("t2_bad_bytes", bad_bytes, e_bad_b, 40);
        lit("t2_runt_frames", runt_frames, e_runt, 1);
        lit("t2_good_frames", good_frames, e_good_f, 1);
        lit("t2_good_bytes", good_bytes, e_good_b, 64);

        // Reset during a frame, released with 30 beats left; then a 100-byte frame.
        rst_n = 1'b0;
        send_frame(130, 1'b0, 1'b0, 100);
        send_frame(100, 1'b0, 1'b0);
        idle(2);
        snap_check();
        lit("t3_good_frames", good_frames, e_good_f, 1);
        lit("t3_good_bytes", good_bytes, e_good_b, 100);
        lit("t3_bad_frames", bad_frames, e_bad_f, 0);

        // Clear and snapshot the cycle right after a 70-byte tlast.
        send_frame(70, 1'b0, 1'b0);
        req(1'b1, 1'b1);
        wait_snap_valid();
        lit("t4_pre_good_frames", good_frames, e_good_f, 1);
        lit("t4_pre_good_bytes", good_bytes, e_good_b, 100);
        idle(1);
        snap_check();
        lit("t4_post_good_frames", good_frames, e_good_f, 1);
        lit("t4_post_good_bytes", good_bytes, e_good_b, 70);

        // 1519-byte good frame with gaps.
        req(1'b0, 1'b1);
        send_frame(1519, 1'b0, 1'b1);
        idle(2);
        snap_check();
        lit("t5_good_bytes", good_bytes, e_good_b, 1519);
        lit("t5_oversize", oversize_frames, e_over, 64'(OVER_EN));

        // Two back-to-back 64-byte frames with tvalid toggling inside.
        req(1'b0, 1'b1);
        send_frame(64, 1'b0, 1'b1);
        send_frame(64, 1'b0, 1'b1);
        idle(2);
        snap_check();
        lit("t6_good_frames", good_frames, e_good_f, 2);
        lit("t6_good_bytes", good_bytes, e_good_b, 128);

        // Length counter saturation at 0xFFFF.
        req(1'b0, 1'b1);
        send_frame(65540, 1'b1, 1'b0);
        idle(2);
        snap_check();
        lit("t7_bad_bytes", bad_bytes, e_bad_b, 65535);
        lit("t7_last_len", last_frame_len, 64'(e_last_len), 65535);
        lit("t7_oversize", oversize_frames, e_over, 64'(OVER_EN));

        // Randomized traffic with random snapshot/clear pulses.
        rand_reqs = 1'b1;
        for (int k = 0; k < 50; k++) begin
            int r;
            int len;
            r = $urandom_range(0, 19);
            if (r < 2)       len = 1;
            else if (r < 5)  len = $urandom_range(60, 68);
            else if (r == 5) len = $urandom_range(1515, 1522);
            else             len = $urandom_range(2, 150);
            send_frame(len, 1'($urandom), 1'($urandom));
            idle($urandom_range(0, 2));
        end
        rand_reqs = 1'b0;
        idle(2);
        snap_check();
        idle(2);

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
